// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: LSU state encoding, decoder enums moved here so the
// decoder and the memory interface agree on them, and byte-lane helpers.
package rv32_pkg;

    localparam int unsigned BYTE_LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ABORT
    } lsu_state_t;

    typedef enum logic [3:0] {
        FOP_ADD,
        FOP_SUB,
        FOP_AND,
        FOP_OR,
        FOP_XOR,
        FOP_SLT,
        FOP_SLTU,
        FOP_SLL,
        FOP_SRL,
        FOP_SRA
    } fop_t;

    typedef enum logic [2:0] {
        B_NONE,
        B_EQ,
        B_NE,
        B_LT,
        B_GE,
        B_LTU,
        B_GEU
    } b_t;

    typedef enum logic [2:0] {
        INST_R,
        INST_I,
        INST_S,
        INST_B,
        INST_U,
        INST_J
    } inst_type;

    // One-hot lane enable for a byte access at lane b.
    function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [1:0] b);
        return BYTE_LANES'(1) << b;
    endfunction

endpackage

// File: rtl/data_mem_interface_if.sv
// Data bus between the load/store unit (master) and memory (slave).
// Signals: bus_addr/bus_wdata/bus_byte_en/bus_read/bus_write (master->slave),
//          bus_rdata/bus_ack (slave->master).
interface data_mem_interface_if
    import rv32_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    logic [ADDR_W-1:0]     bus_addr;
    logic [31:0]           bus_wdata;
    logic [BYTE_LANES-1:0] bus_byte_en;
    logic                  bus_read;
    logic                  bus_write;
    logic [31:0]           bus_rdata;
    logic                  bus_ack;

    modport master (
        output bus_addr, bus_wdata, bus_byte_en, bus_read, bus_write,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_byte_en, bus_read, bus_write,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/data_mem_interface_load_align.sv
// load_align: selects the addressed byte lane and sign-extends it for lb;
// passes the full word through for lw. Purely combinational.
// Ports: rdata (bus word), b (byte offset), is_byte -> data (writeback value).
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  b,
    input  logic        is_byte,
    output logic [31:0] data
);

    logic [7:0] lane_c;

    always_comb begin
        lane_c = rdata[{b, 3'b000} +: 8];
        data   = is_byte ? {{24{lane_c[7]}}, lane_c} : rdata;
    end

endmodule

// File: rtl/data_mem_interface.sv
// data_mem_interface: executes decoded loads/stores over a req/ack data bus,
// stalls the pipeline while a transfer is outstanding and returns lw/lb data.
// Ports: clk, rst (sync, active high); read_mem/write_mem/load_byte/store_byte,
//        addr, store_data from the pipeline; mem_stall, load_data, mem_err back;
//        bus (data_mem_interface_if.master) towards memory.
// Option: MISALIGN_CHECK_EN aborts word accesses with addr[1:0]!=0 without
//         touching the bus; otherwise such accesses are aligned down.
// mem_stall is combinational: it must rise in the same cycle the request appears.
module data_mem_interface
    import rv32_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_mem,
    input  logic                 write_mem,
    input  logic                 load_byte,
    input  logic                 store_byte,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [31:0]          store_data,
    output logic                 mem_stall,
    output logic [31:0]          load_data,
    output logic                 mem_err,
    data_mem_interface_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_write_q, is_write_d;
    logic                  is_byte_q, is_byte_d;
    logic [1:0]            lane_q, lane_d;
    logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
    logic [31:0]           bus_wdata_q, bus_wdata_d;
    logic [BYTE_LANES-1:0] bus_byte_en_q, bus_byte_en_d;
    logic                  bus_read_q, bus_read_d;
    logic                  bus_write_q, bus_write_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  mem_err_q, mem_err_d;

    logic                  req_c;
    logic                  req_byte_c;
    logic                  misalign_c;
    logic [31:0]           aligned_c;

    assign req_c      = read_mem | write_mem;
    assign req_byte_c = write_mem ? store_byte : load_byte;

`ifdef MISALIGN_CHECK_EN
    assign misalign_c = ~req_byte_c & (addr[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    load_align u_load_align (
        .rdata   (bus.bus_rdata),
        .b       (lane_q),
        .is_byte (is_byte_q),
        .data    (aligned_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_write_d    = is_write_q;
        is_byte_d     = is_byte_q;
        lane_d        = lane_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_byte_en_d = bus_byte_en_q;
        bus_read_d    = bus_read_q;
        bus_write_d   = bus_write_q;
        load_data_d   = load_data_q;
        mem_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_c) begin
                    // write_mem wins when both requests are raised
                    is_write_d = write_mem;
                    is_byte_d  = req_byte_c;
                    lane_d     = addr[1:0];
                    if (misalign_c) begin
                        state_d   = ABORT;
                        mem_err_d = 1'b1;
                        if (!write_mem) begin
                            load_data_d = '0;
                        end
                    end else begin
                        state_d       = BUSY;
                        bus_read_d    = ~write_mem;
                        bus_write_d   = write_mem;
                        bus_addr_d    = {addr[ADDR_W-1:2], 2'b00};
                        bus_byte_en_d = (write_mem && store_byte) ? lane_mask(addr[1:0])
                                                                  : {BYTE_LANES{1'b1}};
                        bus_wdata_d   = (write_mem && store_byte) ? {BYTE_LANES{store_data[7:0]}}
                                                                  : store_data;
                    end
                end
            end
            BUSY: begin
                if (bus.bus_ack) begin
                    state_d     = DONE;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    if (!is_write_q) begin
                        load_data_d = aligned_c;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ABORT;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    mem_err_d   = 1'b1;
                    if (!is_write_q) begin
                        load_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            is_write_q    <= 1'b0;
            is_byte_q     <= 1'b0;
            lane_q        <= 2'b00;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_byte_en_q <= '0;
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            load_data_q   <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_write_q    <= is_write_d;
            is_byte_q     <= is_byte_d;
            lane_q        <= lane_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_byte_en_q <= bus_byte_en_d;
            bus_read_q    <= bus_read_d;
            bus_write_q   <= bus_write_d;
            load_data_q   <= load_data_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign mem_stall       = (state_q == BUSY) || ((state_q == IDLE) && req_c);
    assign load_data       = load_data_q;
    assign mem_err         = mem_err_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wdata   = bus_wdata_q;
    assign bus.bus_byte_en = bus_byte_en_q;
    assign bus.bus_read    = bus_read_q;
    assign bus.bus_write   = bus_write_q;

endmodule

// File: tb/tb_data_mem_interface.sv
// Testbench for data_mem_interface: directed vector table, a reset-in-flight
// sequence and randomized transactions checked against a transaction-level model.
module tb_data_mem_interface;

    localparam int unsigned TO = 4;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        bit          wr;
        bit          byt;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_at;    // bus cycle carrying ack, 0 = never
        int          exp_bus;
        bit          exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_mem, write_mem, load_byte, store_byte;
    logic [31:0] addr, store_data;
    logic        mem_stall, mem_err;
    logic [31:0] load_data;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] ref_load;

    data_mem_interface_if #(.ADDR_W(32)) bus_if ();

    data_mem_interface #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_mem   (read_mem),
        .write_mem  (write_mem),
        .load_byte  (load_byte),
        .store_byte (store_byte),
        .addr       (addr),
        .store_data (store_data),
        .mem_stall  (mem_stall),
        .load_data  (load_data),
        .mem_err    (mem_err),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s actual=%h expected=%h", tag, what, act, exp);
    endtask

    // Transaction-level reference: what the bus and pipeline should see.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        vec_t        r;
        int unsigned b;
        logic [31:0] byv;
        r   = v;
        b   = v.addr % 4;
        byv = (v.rdata >> (8 * b)) & 32'hFF;
        r.exp_be    = (v.wr && v.byt) ? 4'(1 << b) : 4'hF;
        r.exp_wdata = v.byt ? (v.sdata & 32'hFF) * 32'h0101_0101 : v.sdata;
        if (MIS && !v.byt && b != 0) begin
            r.exp_bus = 0; r.exp_err = 1'b1; r.exp_load = v.wr ? prev : 32'h0;
        end else if (v.ack_at == 0) begin
            r.exp_bus = TO; r.exp_err = 1'b1; r.exp_load = v.wr ? prev : 32'h0;
        end else begin
            r.exp_bus = v.ack_at; r.exp_err = 1'b0;
            r.exp_load = v.wr ? prev : (v.byt ? ((byv >= 128) ? byv + 32'hFFFF_FF00 : byv) : v.rdata);
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int nbus   = 0;
        int nstall = 0;
        int nerr   = 0;
        bit done   = 0;
        bit fchk   = 0;
        @(posedge clk); #1;
        read_mem = ~v.wr; write_mem = v.wr; load_byte = v.byt; store_byte = v.byt;
        addr = v.addr; store_data = v.sdata; bus_if.bus_rdata = v.rdata; bus_if.bus_ack = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (mem_stall) nstall++;
            if (mem_err) nerr++;
            if (bus_if.bus_read || bus_if.bus_write) begin
                nbus++;
                if (!fchk) begin
                    fchk = 1;
                    chk(tag, "bus_addr", bus_if.bus_addr, v.addr & 32'hFFFF_FFFC);
                    chk(tag, "byte_en", 32'(bus_if.bus_byte_en), 32'(v.exp_be));
                    chk(tag, "bus_write", 32'(bus_if.bus_write), 32'(v.wr));
                    chk(tag, "bus_read", 32'(bus_if.bus_read), 32'(!v.wr));
                    if (v.wr) chk(tag, "wdata", bus_if.bus_wdata, v.exp_wdata);
                end
                bus_if.bus_ack = (v.ack_at != 0) && (nbus == v.ack_at);
            end else begin
                bus_if.bus_ack = 1'b0;
            end
            if (cyc > 0 && !mem_stall) done = 1;
        end
        chk(tag, "completed_in_bound", 32'(done), 32'd1);
        chk(tag, "bus_cycles", 32'(nbus), 32'(v.exp_bus));
        chk(tag, "stall_cycles", 32'(nstall), 32'(v.exp_bus + 1));
        chk(tag, "err_cycles", 32'(nerr), 32'(v.exp_err));
        chk(tag, "load_data", load_data, v.exp_load);
        @(posedge clk); #1;
        read_mem = 0; write_mem = 0; bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk(tag, "idle_err", 32'(mem_err), 32'd0);
        chk(tag, "idle_stall", 32'(mem_stall), 32'd0);
        chk(tag, "idle_bus", 32'(bus_if.bus_read | bus_if.bus_write), 32'd0);
        chk(tag, "idle_load_hold", load_data, v.exp_load);
    endtask

    vec_t dir[9];

    initial begin
        //        wr byt addr          sdata         rdata         ack bus              err  be     wdata         load
        dir[0] = '{0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 3,               0,   4'hF,  32'h0,        32'hDEADBEEF};
        dir[1] = '{0, 1, 32'h103, 32'h0,        32'h80FF0000, 1, 1,               0,   4'hF,  32'h0,        32'hFFFFFF80};
        dir[2] = '{0, 1, 32'h102, 32'h0,        32'h80FF0000, 1, 1,               0,   4'hF,  32'h0,        32'hFFFFFFFF};
        dir[3] = '{1, 1, 32'h201, 32'h12345678, 32'h0,        1, 1,               0,   4'b0010, 32'h78787878, 32'hFFFFFFFF};
        dir[4] = '{0, 0, 32'h104, 32'h0,        32'h55555555, 0, TO,              1,   4'hF,  32'h0,        32'h0};
        dir[5] = '{1, 0, 32'h302, 32'hAABBCCDD, 32'h0,        2, MIS ? 0 : 2,     MIS, 4'hF,  32'hAABBCCDD, 32'h0};
        dir[6] = '{0, 1, 32'h100, 32'h0,        32'h0000007F, 1, 1,               0,   4'hF,  32'h0,        32'h0000007F};
        dir[7] = '{1, 0, 32'h204, 32'hCAFEF00D, 32'h0,        0, TO,              1,   4'hF,  32'hCAFEF00D, 32'h0000007F};
        dir[8] = '{0, 0, 32'h105, 32'h0,        32'h11223344, 2, MIS ? 0 : 2,     MIS, 4'hF,  32'h0,        MIS ? 32'h0 : 32'h11223344};

        rst = 1'b1; read_mem = 0; write_mem = 0; load_byte = 0; store_byte = 0;
        addr = '0; store_data = '0; bus_if.bus_rdata = '0; bus_if.bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset", "load_data", load_data, 32'h0);
        chk("reset", "mem_err", 32'(mem_err), 32'd0);
        chk("reset", "mem_stall", 32'(mem_stall), 32'd0);
        chk("reset", "bus_rw", 32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
        chk("reset", "bus_addr", bus_if.bus_addr, 32'h0);
        chk("reset", "byte_en", 32'(bus_if.bus_byte_en), 32'd0);
        chk("reset", "wdata", bus_if.bus_wdata, 32'h0);

        for (int i = 0; i < 9; i++) run_txn(dir[i], $sformatf("dir%0d", i));

        // Reset while a load is waiting on the bus.
        @(posedge clk); #1;
        read_mem = 1; load_byte = 0; addr = 32'h40; bus_if.bus_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", "bus_read_before", 32'(bus_if.bus_read), 32'd1);
        rst = 1'b1; read_mem = 0;
        @(negedge clk);
        chk("rst_busy", "bus_read", 32'(bus_if.bus_read), 32'd0);
        chk("rst_busy", "mem_stall", 32'(mem_stall), 32'd0);
        chk("rst_busy", "mem_err", 32'(mem_err), 32'd0);
        chk("rst_busy", "load_data", load_data, 32'h0);
        rst = 1'b0;
        ref_load = 32'h0;
        @(negedge clk);
        chk("rst_busy", "no_late_err", 32'(mem_err), 32'd0);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.wr     = $urandom_range(0, 1) == 1;
            v.byt    = $urandom_range(0, 1) == 1;
            v.addr   = $urandom;
            v.sdata  = $urandom;
            v.rdata  = $urandom;
            v.ack_at = $urandom_range(0, TO);
            v        = model(v, ref_load);
            ref_load = v.exp_load;
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
